// File: rtl/sipo_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sipo_deserializer: framed serial-in, parallel-out receiver, valid/ready out |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sipo_deserializer #(
   parameter int W         = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CW        = $clog2(W)
) (
   input  logic          c,
   input  logic          rst,
   input  logic          sin,
   input  logic          sin_en,
   input  logic          sof,
   output logic [W-1:0]  q,
   output logic          q_valid,
   input  logic          q_ready,
   output logic          overrun,
   output logic          frame_err,
   output logic [CW-1:0] bit_cnt
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    sr, sr_nxt;
   logic [CW-1:0]   cnt_nxt;
   logic [W-1:0]    q_nxt;
   logic            q_valid_nxt;
   logic            overrun_nxt;
   logic            frame_err_nxt;
   logic [W-1:0]    shifted;
   logic [W-1:0]    first_bit;
   logic            complete;

   // first_bit is the shift result of a cleared register, used when sof restarts a word
   if (MSB_FIRST) begin : g_msb
      assign shifted   = {sr[W-2:0], sin};
      assign first_bit = {{(W-1){1'b0}}, sin};
   end else begin : g_lsb
      assign shifted   = {sin, sr[W-1:1]};
      assign first_bit = {sin, {(W-1){1'b0}}};
   end

   always_ff @(posedge c) begin
      if (rst) begin
         state     <= IDLE;
         sr        <= '0;
         bit_cnt   <= '0;
         q         <= '0;
         q_valid   <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         sr        <= sr_nxt;
         bit_cnt   <= cnt_nxt;
         q         <= q_nxt;
         q_valid   <= q_valid_nxt;
         overrun   <= overrun_nxt;
         frame_err <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sr_nxt        = sr;
      cnt_nxt       = bit_cnt;
      frame_err_nxt = 1'b0;
      complete      = 1'b0;

      if (sin_en) begin
         case (state)
            IDLE: begin
               if (sof) begin
                  sr_nxt    = first_bit;
                  cnt_nxt   = CW'(1);
                  state_nxt = SHIFT;
               end
            end
            SHIFT: begin
               if (sof) begin
                  sr_nxt        = first_bit;
                  cnt_nxt       = CW'(1);
                  frame_err_nxt = (bit_cnt != '0);
               end else begin
                  sr_nxt = shifted;
                  if (bit_cnt == CW'(W - 1)) begin
                     cnt_nxt  = '0;
                     complete = 1'b1;
                  end else begin
                     cnt_nxt = bit_cnt + CW'(1);
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // A completed word may replace q only if q is empty or being consumed this cycle
   always_comb begin
      q_nxt       = q;
      q_valid_nxt = q_valid;
      overrun_nxt = overrun;
      if (complete) begin
         if (!q_valid || q_ready) begin
            q_nxt       = shifted;
            q_valid_nxt = 1'b1;
         end else begin
            overrun_nxt = 1'b1;
         end
      end else if (q_valid && q_ready) begin
         q_valid_nxt = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sipo_deserializer: random + directed bench with a queue-based ref model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_sipo_deserializer;

   localparam int W  = 4;
   localparam int CW = $clog2(W);

   logic c = 1'b0;
   logic rst = 1'b1;
   logic sin = 1'b0;
   logic sin_en = 1'b0;
   logic sof = 1'b0;
   logic q_ready = 1'b0;

   logic [W-1:0]  q_m, q_l;
   logic          v_m, v_l, o_m, o_l, fe_m, fe_l;
   logic [CW-1:0] bc_m, bc_l;

   sipo_deserializer #(.W(W), .MSB_FIRST(1'b1)) dut_m (
      .c(c), .rst(rst), .sin(sin), .sin_en(sin_en), .sof(sof),
      .q(q_m), .q_valid(v_m), .q_ready(q_ready),
      .overrun(o_m), .frame_err(fe_m), .bit_cnt(bc_m)
   );

   sipo_deserializer #(.W(W), .MSB_FIRST(1'b0)) dut_l (
      .c(c), .rst(rst), .sin(sin), .sin_en(sin_en), .sof(sof),
      .q(q_l), .q_valid(v_l), .q_ready(q_ready),
      .overrun(o_l), .frame_err(fe_l), .bit_cnt(bc_l)
   );

   always #5 c = ~c;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: received bits kept as an ordered list
   bit           in_frame;
   bit           bits[$];
   logic [W-1:0] eq_m, eq_l;
   bit           ev, eo, efe;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit en, input bit s, input bit d, input bit rdy);
      bit           done;
      logic [W-1:0] wm, wl;
      if (r) begin
         in_frame = 1'b0;
         bits.delete();
         eq_m = '0; eq_l = '0; ev = 1'b0; eo = 1'b0; efe = 1'b0;
         return;
      end
      efe  = 1'b0;
      done = 1'b0;
      wm   = '0;
      wl   = '0;
      if (en) begin
         if (s) begin
            if (in_frame && bits.size() != 0) efe = 1'b1;
            bits.delete();
            bits.push_back(d);
            in_frame = 1'b1;
         end else if (in_frame) begin
            bits.push_back(d);
            if (bits.size() == W) begin
               done = 1'b1;
               for (int i = 0; i < W; i++) begin
                  wm    = (wm << 1) | W'(bits[i]);
                  wl[i] = bits[i];
               end
               bits.delete();
            end
         end
      end
      if (done) begin
         if (!ev || rdy) begin
            eq_m = wm; eq_l = wl; ev = 1'b1;
         end else begin
            eo = 1'b1;
         end
      end else if (ev && rdy) begin
         ev = 1'b0;
      end
   endtask

   task automatic step(input bit r, input bit en, input bit s, input bit d, input bit rdy);
      rst = r; sin_en = en; sof = s; sin = d; q_ready = rdy;
      @(posedge c);
      model_edge(r, en, s, d, rdy);
      #1;
      chk("q_msb",     32'(q_m),  32'(eq_m));
      chk("q_lsb",     32'(q_l),  32'(eq_l));
      chk("valid_msb", 32'(v_m),  32'(ev));
      chk("valid_lsb", 32'(v_l),  32'(ev));
      chk("ovr_msb",   32'(o_m),  32'(eo));
      chk("ovr_lsb",   32'(o_l),  32'(eo));
      chk("ferr_msb",  32'(fe_m), 32'(efe));
      chk("ferr_lsb",  32'(fe_l), 32'(efe));
      chk("cnt_msb",   32'(bc_m), 32'(bits.size()));
      chk("cnt_lsb",   32'(bc_l), 32'(bits.size()));
   endtask

   // Sends a word in arrival order: w[W-1] first
   task automatic send(input logic [W-1:0] w, input bit with_sof, input bit rdy);
      for (int i = W - 1; i >= 0; i--)
         step(1'b0, 1'b1, with_sof && (i == W - 1), w[i], rdy);
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("rst_q",     32'(q_m), 32'h0);
      chk("rst_valid", 32'(v_m), 32'h0);

      // Basic word, both bit orders
      send(4'b0011, 1'b1, 1'b1);
      chk("basic_q_msb", 32'(q_m), 32'h3);
      chk("basic_q_lsb", 32'(q_l), 32'hC);
      step(0, 0, 0, 0, 1);
      chk("basic_consumed", 32'(v_m), 32'h0);

      // Back-to-back words without a second sof
      send(4'b1010, 1'b1, 1'b1);
      chk("b2b_q0", 32'(q_m), 32'hA);
      send(4'b0110, 1'b0, 1'b1);
      chk("b2b_q1", 32'(q_m), 32'h6);
      step(0, 0, 0, 0, 1);

      // Backpressure and sticky overrun
      send(4'b1001, 1'b1, 1'b0);
      send(4'b0111, 1'b0, 1'b0);
      chk("bp_hold", 32'(q_m), 32'h9);
      chk("bp_ovr",  32'(o_m), 32'h1);
      step(0, 0, 0, 0, 1);
      chk("bp_drain",  32'(v_m), 32'h0);
      step(0, 0, 0, 0, 1);
      chk("bp_sticky", 32'(o_m), 32'h1);
      step(1, 0, 0, 0, 0);

      // Resync mid-word
      step(0, 1, 1, 1, 1);
      step(0, 1, 0, 1, 1);
      step(0, 1, 1, 0, 1);
      chk("resync_ferr", 32'(fe_m), 32'h1);
      step(0, 1, 0, 1, 1);
      chk("resync_pulse", 32'(fe_m), 32'h0);
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 1, 1);
      chk("resync_q", 32'(q_m), 32'h5);
      step(1, 0, 0, 0, 0);

      // Idle gaps, ignored beats in IDLE, reset mid-word
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      chk("idle_ign", 32'(bc_m), 32'h0);
      step(0, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 1, 0);
      chk("gap_q", 32'(q_m), 32'hB);
      step(0, 1, 1, 1, 1);
      step(0, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      chk("mid_rst_cnt",   32'(bc_m), 32'h0);
      chk("mid_rst_valid", 32'(v_m),  32'h0);
      send(4'b1101, 1'b1, 1'b0);
      chk("post_rst_q", 32'(q_m), 32'hD);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 11) == 0,
              1'($urandom),
              $urandom_range(0, 9) < 6);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
